// File: rtl/booth_pkg.sv
// Shared types and width helper for the radix-4 Booth multiplier slice.
package booth_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  typedef enum logic [2:0] {PP_ZERO, PP_POS1, PP_POS2, PP_NEG1, PP_NEG2} pp_sel_e;

  // Smallest even width holding an N-bit operand plus one extension bit.
  function automatic int ext_width(input int n);
    return 2 * ((n + 2) / 2);
  endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder: {Q[1], Q[0], q-1} -> partial-product select.
module booth_r4_encoder
  import booth_pkg::*;
(
  input  logic [2:0] trip,
  output pp_sel_e    sel
);

  always_comb begin
    sel = PP_ZERO;
    case (trip)
      3'b000, 3'b111: sel = PP_ZERO;
      3'b001, 3'b010: sel = PP_POS1;
      3'b011:         sel = PP_POS2;
      3'b100:         sel = PP_NEG2;
      default:        sel = PP_NEG1;
    endcase
  end

endmodule

// File: rtl/booth_r4_mult_seq.sv
// Sequential radix-4 Booth multiplier, signed/unsigned, start/busy/done handshake.
module booth_r4_mult_seq
  import booth_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   data_M,
  input  logic [N-1:0]   data_Q,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] data_out
);

  localparam int E    = ext_width(N);
  localparam int ITER = E / 2;
  localparam int CW   = $clog2(ITER + 1);

  state_e           state_q, state_d;
  logic [E-1:0]     m_q, m_d;
  logic [E-1:0]     q_q, q_d;
  logic [E+1:0]     a_q, a_d;
  logic             qm1_q, qm1_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2*N-1:0]   data_out_q, data_out_d;

  pp_sel_e          sel;
  logic             accept;
  logic             neg;
  logic [E+1:0]     m_wide, mag, addend, a_sum, a_nxt;
  logic [E-1:0]     q_nxt;

  booth_r4_encoder u_enc (
    .trip ({q_q[1:0], qm1_q}),
    .sel  (sel)
  );

  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    q_d        = q_q;
    a_d        = a_q;
    qm1_d      = qm1_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;

    // Negative selects reuse the adder: invert the magnitude, carry in one.
    m_wide = {{2{m_q[E-1]}}, m_q};
    mag    = (sel == PP_POS2 || sel == PP_NEG2) ? {m_wide[E:0], 1'b0} : m_wide;
    neg    = (sel == PP_NEG1 || sel == PP_NEG2);
    addend = (sel == PP_ZERO) ? '0 : (neg ? ~mag : mag);
    a_sum  = a_q + addend + {{(E+1){1'b0}}, neg};
    a_nxt  = {{2{a_sum[E+1]}}, a_sum[E+1:2]};
    q_nxt  = {a_sum[1:0], q_q[E-1:2]};

    accept = start && (state_q != RUN);

    case (state_q)
      IDLE: state_d = IDLE;
      RUN: begin
        a_d   = a_nxt;
        q_d   = q_nxt;
        qm1_d = q_q[1];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d    = DONE;
          data_out_d = (2*N)'({a_nxt, q_nxt});
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = RUN;
      m_d     = {{(E-N){signed_mode & data_M[N-1]}}, data_M};
      q_d     = {{(E-N){signed_mode & data_Q[N-1]}}, data_Q};
      a_d     = '0;
      qm1_d   = 1'b0;
      cnt_d   = CW'(ITER);
    end

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      m_q        <= '0;
      q_q        <= '0;
      a_q        <= '0;
      qm1_q      <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      q_q        <= q_d;
      a_q        <= a_d;
      qm1_q      <= qm1_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      data_out_q <= data_out_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_booth_r4_mult_seq.sv
// Self-checking bench for booth_r4_mult_seq at N=4, N=5 and N=8.
module tb_booth_r4_mult_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start4 = 0, sm4 = 0, busy4, done4;
  logic [3:0] m4 = '0, q4 = '0;
  logic [7:0] out4;
  logic       start5 = 0, sm5 = 0, busy5, done5;
  logic [4:0] m5 = '0, q5 = '0;
  logic [9:0] out5;
  logic       start8 = 0, sm8 = 0, busy8, done8;
  logic [7:0] m8 = '0, q8 = '0;
  logic [15:0] out8;

  booth_r4_mult_seq #(.N(4)) u4 (.clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sm4),
    .data_M(m4), .data_Q(q4), .busy(busy4), .done(done4), .data_out(out4));
  booth_r4_mult_seq #(.N(5)) u5 (.clk(clk), .rst_n(rst_n), .start(start5), .signed_mode(sm5),
    .data_M(m5), .data_Q(q5), .busy(busy5), .done(done5), .data_out(out5));
  booth_r4_mult_seq #(.N(8)) u8 (.clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
    .data_M(m8), .data_Q(q8), .busy(busy8), .done(done8), .data_out(out8));

  int n_cmp = 0;
  int n_bad = 0;
  int acc4 = 0, acc5 = 0, acc8 = 0;
  int dn4 = 0, dn5 = 0, dn8 = 0;
  logic [7:0]  exp4_q[$];
  logic [9:0]  exp5_q[$];
  logic [15:0] exp8_q[$];

  typedef struct {
    logic       sm;
    logic [3:0] m;
    logic [3:0] q;
    logic [7:0] exp;
  } vec4_t;
  vec4_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: done not seen within cycle budget, required done pulse", name);
  endtask

  // Scoreboard monitors: every done pops one expected product.
  always @(negedge clk) if (rst_n && done4) begin
    dn4++;
    if (exp4_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL u4_done: unexpected done with product %0h, required none", out4);
    end else chk("u4_product", 64'(out4), 64'(exp4_q.pop_front()));
  end
  always @(negedge clk) if (rst_n && done5) begin
    dn5++;
    if (exp5_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL u5_done: unexpected done with product %0h, required none", out5);
    end else chk("u5_product", 64'(out5), 64'(exp5_q.pop_front()));
  end
  always @(negedge clk) if (rst_n && done8) begin
    dn8++;
    if (exp8_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL u8_done: unexpected done with product %0h, required none", out8);
    end else chk("u8_product", 64'(out8), 64'(exp8_q.pop_front()));
  end

  function automatic logic [15:0] ref8(input logic sm, input logic [7:0] m, input logic [7:0] q);
    int a, b;
    a = sm ? int'($signed(m)) : int'(m);
    b = sm ? int'($signed(q)) : int'(q);
    return 16'(a * b);
  endfunction

  task automatic op4(input logic sm, input logic [3:0] m, input logic [3:0] q,
                     input logic [7:0] exp, output int lat, output int bcnt);
    @(posedge clk); #1;
    sm4 = sm; m4 = m; q4 = q; start4 = 1'b1;
    exp4_q.push_back(exp); acc4++;
    @(posedge clk); #1;
    start4 = 1'b0; sm4 = ~sm; m4 = ~m; q4 = ~q;
    lat = 0; bcnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      lat++;
      if (busy4) bcnt++;
      if (done4) break;
    end
    if (!done4) timeout("u4_latency");
  endtask

  task automatic op5(input logic sm, input logic [4:0] m, input logic [4:0] q, input logic [9:0] exp);
    int lat;
    @(posedge clk); #1;
    sm5 = sm; m5 = m; q5 = q; start5 = 1'b1;
    exp5_q.push_back(exp); acc5++;
    @(posedge clk); #1;
    start5 = 1'b0; m5 = ~m;
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      lat++;
      if (done5) break;
    end
    if (!done5) timeout("u5_latency");
    else chk("u5_latency", 64'(lat), 64'd4);
  endtask

  task automatic op8(input logic sm, input logic [7:0] m, input logic [7:0] q);
    @(posedge clk); #1;
    sm8 = sm; m8 = m; q8 = q; start8 = 1'b1;
    exp8_q.push_back(ref8(sm, m, q)); acc8++;
    @(posedge clk); #1;
    start8 = 1'b0; sm8 = $urandom_range(0, 1); m8 = 8'($urandom); q8 = 8'($urandom);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done8) break;
    end
    if (!done8) timeout("u8_latency");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bcnt, gap, ndone;

    tbl[0] = '{1'b1, 4'h8, 4'h8, 8'h40};
    tbl[1] = '{1'b1, 4'h7, 4'h8, 8'hC8};
    tbl[2] = '{1'b0, 4'hF, 4'hF, 8'hE1};
    tbl[3] = '{1'b0, 4'h0, 4'hD, 8'h00};
    tbl[4] = '{1'b1, 4'h3, 4'h5, 8'h0F};
    tbl[5] = '{1'b0, 4'h8, 4'h8, 8'h40};
    tbl[6] = '{1'b1, 4'hF, 4'h7, 8'hF9};
    tbl[7] = '{1'b1, 4'h7, 4'h7, 8'h31};

    repeat (3) @(negedge clk);
    chk("rst_busy4", 64'(busy4), 64'd0);
    chk("rst_done4", 64'(done4), 64'd0);
    chk("rst_out4", 64'(out4), 64'd0);
    chk("rst_out5", 64'(out5), 64'd0);
    chk("rst_out8", 64'(out8), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      op4(tbl[i].sm, tbl[i].m, tbl[i].q, tbl[i].exp, lat, bcnt);
      chk("u4_latency", 64'(lat), 64'd4);
      chk("u4_busy_cycles", 64'(bcnt), 64'd3);
    end
    @(negedge clk);
    chk("u4_done_one_cycle", 64'(done4), 64'd0);
    repeat (3) @(negedge clk);
    chk("u4_out_held", 64'(out4), 64'h31);

    op5(1'b1, 5'h10, 5'h0F, 10'h310);
    op5(1'b0, 5'h1F, 5'h1F, 10'h3C1);
    op5(1'b1, 5'h10, 5'h10, 10'h100);

    // Back-to-back: start held through DONE, operands changed mid-RUN.
    @(posedge clk); #1;
    sm4 = 1'b1; m4 = 4'h7; q4 = 4'h8; start4 = 1'b1;
    exp4_q.push_back(8'hC8); acc4++;
    @(posedge clk); #1;
    m4 = 4'h3; q4 = 4'h5;
    exp4_q.push_back(8'h0F); acc4++;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done4) break;
    end
    if (!done4) timeout("b2b_first");
    @(posedge clk); #1;
    start4 = 1'b0;
    gap = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      gap++;
      if (done4) break;
    end
    if (!done4) timeout("b2b_second");
    else chk("b2b_gap", 64'(gap), 64'd4);

    // A start pulse while running must be ignored.
    @(posedge clk); #1;
    sm4 = 1'b0; m4 = 4'h2; q4 = 4'h3; start4 = 1'b1;
    exp4_q.push_back(8'h06); acc4++;
    @(posedge clk); #1; start4 = 1'b0;
    @(posedge clk); #1; start4 = 1'b1; m4 = 4'hF; q4 = 4'hF;
    @(posedge clk); #1; start4 = 1'b0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done4) ndone++;
    end
    chk("midrun_start_dones", 64'(ndone), 64'd1);
    chk("midrun_out_held", 64'(out4), 64'h06);

    // Asynchronous reset mid-RUN abandons the operation.
    @(posedge clk); #1;
    sm4 = 1'b1; m4 = 4'h5; q4 = 4'h3; start4 = 1'b1;
    @(posedge clk); #1; start4 = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_busy", 64'(busy4), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy4), 64'd0);
    chk("midrst_done", 64'(done4), 64'd0);
    chk("midrst_out", 64'(out4), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    op4(1'b1, 4'hF, 4'hF, 8'h01, lat, bcnt);
    chk("post_rst_latency", 64'(lat), 64'd4);

    op8(1'b1, 8'h80, 8'h80);
    op8(1'b0, 8'hFF, 8'hFF);
    op8(1'b1, 8'hFF, 8'h80);
    op8(1'b1, 8'h7F, 8'h80);
    op8(1'b0, 8'h80, 8'h01);
    for (int i = 0; i < 10000; i++)
      op8(1'($urandom), 8'($urandom), 8'($urandom));

    repeat (4) @(negedge clk);
    chk("u4_done_count", 64'(dn4), 64'(acc4));
    chk("u5_done_count", 64'(dn5), 64'(acc5));
    chk("u8_done_count", 64'(dn8), 64'(acc8));
    chk("u4_queue_empty", 64'(exp4_q.size()), 64'd0);
    chk("u5_queue_empty", 64'(exp5_q.size()), 64'd0);
    chk("u8_queue_empty", 64'(exp8_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
